// File: rtl/tl_pkg.sv
// tl_pkg: shared types and constants for the tail-light pattern decoder.
//   - PAT_* : lamp patterns driven on L[2:0] / R[2:0]
//   - tl_state_e : sequence tracker states
//   - tl_class_e / tl_step_e : result of classifying one L/R sample
//   - ERR_* : err_code values
//   - helper functions mapping between states and (class, step)
package tl_pkg;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_A   = 3'b001;
  localparam logic [2:0] PAT_B   = 3'b011;
  localparam logic [2:0] PAT_C   = 3'b111;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_INTR    = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LA, ST_LB, ST_LC, ST_RA, ST_RB, ST_RC, ST_HA, ST_HB, ST_HC
  } tl_state_e;

  typedef enum logic [2:0] {
    CL_OFF, CL_LEFT, CL_RIGHT, CL_HAZ, CL_ILLEGAL
  } tl_class_e;

  typedef enum logic [1:0] {
    STEP_A, STEP_B, STEP_C
  } tl_step_e;

  // Sequence type tracked by a state (CL_OFF for IDLE).
  function automatic tl_class_e st_class(tl_state_e s);
    case (s)
      ST_LA, ST_LB, ST_LC: return CL_LEFT;
      ST_RA, ST_RB, ST_RC: return CL_RIGHT;
      ST_HA, ST_HB, ST_HC: return CL_HAZ;
      default:             return CL_OFF;
    endcase
  endfunction

  // Last step seen in a state (meaningless for IDLE).
  function automatic tl_step_e st_step(tl_state_e s);
    case (s)
      ST_LB, ST_RB, ST_HB: return STEP_B;
      ST_LC, ST_RC, ST_HC: return STEP_C;
      default:             return STEP_A;
    endcase
  endfunction

  // State reached after accepting a step of the given class.
  function automatic tl_state_e st_of(tl_class_e c, tl_step_e p);
    case (c)
      CL_LEFT:  return (p == STEP_A) ? ST_LA : (p == STEP_B) ? ST_LB : ST_LC;
      CL_RIGHT: return (p == STEP_A) ? ST_RA : (p == STEP_B) ? ST_RB : ST_RC;
      CL_HAZ:   return (p == STEP_A) ? ST_HA : (p == STEP_B) ? ST_HB : ST_HC;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tail_light_decoder_if.sv
// tail_light_decoder_if: lamp pattern bus from the turn-signal controller.
//   sample_en : L/R carry a valid pattern this cycle
//   L, R      : left / right lamp patterns
// master = pattern source (controller or bench), slave = decoder.
interface tail_light_decoder_if;
  logic       sample_en;
  logic [2:0] L;
  logic [2:0] R;

  modport master (output sample_en, output L, output R);
  modport slave  (input  sample_en, input  L, input  R);
endinterface

// File: rtl/tl_pattern_classify.sv
// tl_pattern_classify: combinational classification of one L/R sample.
//   i_L, i_R : lamp patterns
//   o_class  : OFF / LEFT / RIGHT / HAZ / ILLEGAL
//   o_step   : A/B/C step of a legal non-OFF pattern (STEP_A otherwise)
module tl_pattern_classify
  import tl_pkg::*;
(
  input  logic [2:0] i_L,
  input  logic [2:0] i_R,
  output tl_class_e  o_class,
  output tl_step_e   o_step
);

  function automatic logic is_lit(logic [2:0] p);
    return (p == PAT_A) || (p == PAT_B) || (p == PAT_C);
  endfunction

  function automatic tl_step_e step_of(logic [2:0] p);
    case (p)
      PAT_A:   return STEP_A;
      PAT_B:   return STEP_B;
      default: return STEP_C;
    endcase
  endfunction

  always_comb begin
    o_class = CL_ILLEGAL;
    o_step  = STEP_A;
    if (i_L == PAT_OFF && i_R == PAT_OFF) begin
      o_class = CL_OFF;
    end else if (is_lit(i_L) && i_R == PAT_OFF) begin
      o_class = CL_LEFT;
      o_step  = step_of(i_L);
    end else if (i_L == PAT_OFF && is_lit(i_R)) begin
      o_class = CL_RIGHT;
      o_step  = step_of(i_R);
    end else if (i_L == i_R && is_lit(i_L)) begin
      o_class = CL_HAZ;
      o_step  = step_of(i_L);
    end
  end

endmodule

// File: rtl/tail_light_decoder.sv
// tail_light_decoder: receive-side checker for the tail-light pattern stream.
// Tracks left / right / hazard A->B->C->OFF sequences on sampled L/R,
// pulses *_done on completion and err on protocol violations.
//   Clk, reset    : clock, async active-high reset
//   pat (slave)   : sample_en, L, R
//   busy          : inside a sequence
//   left_done, right_done, hazard_done, err : one-cycle registered pulses
//   err_code      : cause of the last error (held)
//   seq_cnt       : completed sequences, wrapping
//   left_cnt, right_cnt, hazard_cnt, err_cnt : saturating statistics,
//                   present only when TL_DEC_STATS_EN is defined, else 0
//
// state | meaning
// IDLE  | no sequence in progress
// xA    | x in {L,R,H}: A step seen
// xB    | A,B steps seen
// xC    | A,B,C steps seen, waiting for OFF
module tail_light_decoder
  import tl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              Clk,
  input  logic              reset,
  tail_light_decoder_if.slave pat,
  output logic              busy,
  output logic              left_done,
  output logic              right_done,
  output logic              hazard_done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  seq_cnt,
  output logic [CNT_W-1:0]  left_cnt,
  output logic [CNT_W-1:0]  right_cnt,
  output logic [CNT_W-1:0]  hazard_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  tl_class_e        w_class;
  tl_step_e         w_step;
  tl_class_e        w_cur_class;
  tl_step_e         w_cur_step;
  logic             w_advance;

  tl_state_e        r_state;
  logic             r_left_done, r_right_done, r_hazard_done, r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_seq_cnt;
`ifdef TL_DEC_STATS_EN
  logic [CNT_W-1:0] r_left_cnt, r_right_cnt, r_hazard_cnt, r_err_cnt;
`endif

  tl_pattern_classify u_classify (
    .i_L     (pat.L),
    .i_R     (pat.R),
    .o_class (w_class),
    .o_step  (w_step)
  );

  assign w_cur_class = st_class(r_state);
  assign w_cur_step  = st_step(r_state);
  // Only the immediate next step of the same type advances; a repeat is a mismatch.
  assign w_advance   = (w_class == w_cur_class) &&
                       (((w_cur_step == STEP_A) && (w_step == STEP_B)) ||
                        ((w_cur_step == STEP_B) && (w_step == STEP_C)));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_left_done   <= 1'b0;
      r_right_done  <= 1'b0;
      r_hazard_done <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 2'b00;
      r_seq_cnt     <= '0;
`ifdef TL_DEC_STATS_EN
      r_left_cnt    <= '0;
      r_right_cnt   <= '0;
      r_hazard_cnt  <= '0;
      r_err_cnt     <= '0;
`endif
    end else begin
      r_left_done   <= 1'b0;
      r_right_done  <= 1'b0;
      r_hazard_done <= 1'b0;
      r_err         <= 1'b0;
      if (pat.sample_en) begin
        if (r_state == ST_IDLE) begin
          if (w_class == CL_ILLEGAL) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_ILLEGAL;
`ifdef TL_DEC_STATS_EN
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
`endif
          end else if (w_class != CL_OFF) begin
            if (w_step == STEP_A) begin
              r_state <= st_of(w_class, STEP_A);
            end else begin
              r_err      <= 1'b1;
              r_err_code <= ERR_ORDER;
`ifdef TL_DEC_STATS_EN
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
`endif
            end
          end
        end else if (w_cur_step == STEP_C && w_class == CL_OFF) begin
          r_state   <= ST_IDLE;
          r_seq_cnt <= r_seq_cnt + 1'b1;
          case (w_cur_class)
            CL_LEFT: begin
              r_left_done <= 1'b1;
`ifdef TL_DEC_STATS_EN
              if (r_left_cnt != '1) r_left_cnt <= r_left_cnt + 1'b1;
`endif
            end
            CL_RIGHT: begin
              r_right_done <= 1'b1;
`ifdef TL_DEC_STATS_EN
              if (r_right_cnt != '1) r_right_cnt <= r_right_cnt + 1'b1;
`endif
            end
            default: begin
              r_hazard_done <= 1'b1;
`ifdef TL_DEC_STATS_EN
              if (r_hazard_cnt != '1) r_hazard_cnt <= r_hazard_cnt + 1'b1;
`endif
            end
          endcase
        end else if (w_advance) begin
          r_state <= st_of(w_class, w_step);
        end else begin
          r_err <= 1'b1;
`ifdef TL_DEC_STATS_EN
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
`endif
          if (w_class == CL_ILLEGAL) begin
            r_err_code <= ERR_ILLEGAL;
            r_state    <= ST_IDLE;
          end else if (w_class == CL_OFF) begin
            r_err_code <= ERR_INTR;
            r_state    <= ST_IDLE;
          end else begin
            r_err_code <= ERR_ORDER;
            // An A step of any type restarts tracking immediately.
            r_state    <= (w_step == STEP_A) ? st_of(w_class, STEP_A) : ST_IDLE;
          end
        end
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign left_done   = r_left_done;
  assign right_done  = r_right_done;
  assign hazard_done = r_hazard_done;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign seq_cnt     = r_seq_cnt;
`ifdef TL_DEC_STATS_EN
  assign left_cnt    = r_left_cnt;
  assign right_cnt   = r_right_cnt;
  assign hazard_cnt  = r_hazard_cnt;
  assign err_cnt     = r_err_cnt;
`else
  assign left_cnt    = '0;
  assign right_cnt   = '0;
  assign hazard_cnt  = '0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_tail_light_decoder.sv
// Bench for tail_light_decoder: directed sequences plus random stimulus,
// checked against a sequence-level reference model. Two instances share the
// pattern bus: CNT_W=8 and CNT_W=2 (wrap / saturation).
module tb_tail_light_decoder;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  tail_light_decoder_if pif ();

  logic       busy8, ld8, rd8, hd8, err8;
  logic [1:0] code8;
  logic [7:0] seq8, lc8, rc8, hc8, ec8;
  logic       busy2, ld2, rd2, hd2, err2;
  logic [1:0] code2;
  logic [1:0] seq2, lc2, rc2, hc2, ec2;

  tail_light_decoder #(.CNT_W(8)) dut8 (
    .Clk(Clk), .reset(reset), .pat(pif),
    .busy(busy8), .left_done(ld8), .right_done(rd8), .hazard_done(hd8),
    .err(err8), .err_code(code8), .seq_cnt(seq8),
    .left_cnt(lc8), .right_cnt(rc8), .hazard_cnt(hc8), .err_cnt(ec8)
  );

  tail_light_decoder #(.CNT_W(2)) dut2 (
    .Clk(Clk), .reset(reset), .pat(pif),
    .busy(busy2), .left_done(ld2), .right_done(rd2), .hazard_done(hd2),
    .err(err2), .err_code(code2), .seq_cnt(seq2),
    .left_cnt(lc2), .right_cnt(rc2), .hazard_cnt(hc2), .err_cnt(ec2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sequence type (0 idle, 1 left, 2 right, 3 hazard) and
  // number of steps seen so far.
  int m_typ, m_pos;
  int m_seq;
  int m_cnt [4];            // [0]=errors, [1..3]=left/right/hazard completions
  bit e_done [4];           // [0]=err pulse, [1..3]=done pulses
  logic [1:0] m_code;

  function automatic int lvl(logic [2:0] p);
    case (p)
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] pat_of(int k);
    return (k == 1) ? 3'b001 : (k == 2) ? 3'b011 : 3'b111;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_typ = 0; m_pos = 0; m_seq = 0; m_code = 2'b00;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; e_done[i] = 0; end
  endtask

  task automatic model_err(input logic [1:0] c);
    e_done[0] = 1; m_code = c; m_cnt[0]++;
  endtask

  task automatic model_step(input bit en, input logic [2:0] l, input logic [2:0] r);
    int cls, st;
    for (int i = 0; i < 4; i++) e_done[i] = 0;
    if (!en) return;
    st = 0;
    if (l == 0 && r == 0) cls = 0;
    else if (lvl(l) > 0 && r == 0) begin cls = 1; st = lvl(l); end
    else if (l == 0 && lvl(r) > 0) begin cls = 2; st = lvl(r); end
    else if (l == r && lvl(l) > 0) begin cls = 3; st = lvl(l); end
    else cls = 4;

    if (m_typ == 0) begin
      if (cls == 4) model_err(2'b01);
      else if (cls != 0) begin
        if (st == 1) begin m_typ = cls; m_pos = 1; end
        else model_err(2'b10);
      end
    end else if (m_pos == 3 && cls == 0) begin
      e_done[m_typ] = 1; m_cnt[m_typ]++; m_seq++; m_typ = 0;
    end else if (cls == m_typ && st == m_pos + 1) begin
      m_pos++;
    end else if (cls == 4) begin
      model_err(2'b01); m_typ = 0;
    end else if (cls == 0) begin
      model_err(2'b11); m_typ = 0;
    end else begin
      model_err(2'b10);
      if (st == 1) begin m_typ = cls; m_pos = 1; end
      else m_typ = 0;
    end
  endtask

  task automatic check_all();
    chk("busy8", busy8, m_typ != 0);
    chk("busy2", busy2, m_typ != 0);
    chk("left_done", ld8, e_done[1]);
    chk("right_done", rd8, e_done[2]);
    chk("hazard_done", hd8, e_done[3]);
    chk("err", err8, e_done[0]);
    chk("err_code", code8, m_code);
    chk("pulses2", {ld2, rd2, hd2, err2, code2}, {e_done[1], e_done[2], e_done[3], e_done[0], m_code});
    chk("seq_cnt8", seq8, m_seq % 256);
    chk("seq_cnt2", seq2, m_seq % 4);
`ifdef TL_DEC_STATS_EN
    chk("stats8", {lc8, rc8, hc8, ec8},
        {8'(sat(m_cnt[1], 255)), 8'(sat(m_cnt[2], 255)), 8'(sat(m_cnt[3], 255)), 8'(sat(m_cnt[0], 255))});
    chk("stats2", {lc2, rc2, hc2, ec2},
        {2'(sat(m_cnt[1], 3)), 2'(sat(m_cnt[2], 3)), 2'(sat(m_cnt[3], 3)), 2'(sat(m_cnt[0], 3))});
`else
    chk("stats8", {lc8, rc8, hc8, ec8}, 32'd0);
    chk("stats2", {lc2, rc2, hc2, ec2}, 32'd0);
`endif
  endtask

  // Called at a negedge: drive one sample, advance the model, check one cycle later.
  task automatic cyc(input bit en, input logic [2:0] l, input logic [2:0] r);
    pif.sample_en = en; pif.L = l; pif.R = r;
    model_step(en, l, r);
    @(negedge Clk);
    check_all();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", {busy8, busy2}, 2'b00);
    chk("rst_pulses", {ld8, rd8, hd8, err8, ld2, rd2, hd2, err2}, 8'd0);
    chk("rst_cnt", {seq8, seq2, code8, lc8, ec8}, 32'd0);
    model_reset();
    @(negedge Clk);
    reset = 1'b0;
    pif.sample_en = 1'b0;
  endtask

  task automatic lseq();
    cyc(1, 3'b001, 3'b000); cyc(1, 3'b011, 3'b000);
    cyc(1, 3'b111, 3'b000); cyc(1, 3'b000, 3'b000);
  endtask

  initial begin
    int typ, k, rr;
    logic [2:0] l, r;
    reset = 1'b1;
    pif.sample_en = 1'b0; pif.L = 3'b000; pif.R = 3'b000;
    model_reset();
    repeat (2) @(negedge Clk);
    check_all();
    reset = 1'b0;
    @(negedge Clk);
    check_all();

    // left sequence
    lseq();
    chk("left_seq_cnt", seq8, 8'd1);
    // hazard sequence
    cyc(1, 3'b001, 3'b001); cyc(1, 3'b011, 3'b011);
    cyc(1, 3'b111, 3'b111); cyc(1, 3'b000, 3'b000);
    // interrupt
    cyc(1, 3'b000, 3'b001); cyc(1, 3'b000, 3'b011); cyc(1, 3'b000, 3'b000);
    chk("intr_code", code8, 2'b11);
    // illegal in IDLE, then resync from LB to RA
    cyc(1, 3'b010, 3'b000);
    chk("illegal_code", code8, 2'b01);
    cyc(1, 3'b001, 3'b000); cyc(1, 3'b011, 3'b000);
    cyc(1, 3'b000, 3'b001);
    chk("resync_code", code8, 2'b10);
    cyc(1, 3'b000, 3'b011); cyc(1, 3'b000, 3'b111); cyc(1, 3'b000, 3'b000);
    // sample_en gaps
    for (int s = 1; s <= 4; s++) begin
      cyc(1, (s == 4) ? 3'b000 : pat_of(s), 3'b000);
      repeat (5) cyc(0, 3'($urandom), 3'($urandom));
    end
    // reset during LC
    cyc(1, 3'b001, 3'b000); cyc(1, 3'b011, 3'b000); cyc(1, 3'b111, 3'b000);
    pulse_reset();
    // wrap / saturation on the narrow instance
    repeat (5) lseq();
    chk("wrap_seq2", seq2, 2'd1);
`ifdef TL_DEC_STATS_EN
    chk("sat_left2", lc2, 2'd3);
`else
    chk("sat_left2", lc2, 2'd0);
`endif

    // random stimulus
    for (int n = 0; n < 3000; n++) begin
      rr = $urandom_range(0, 9);
      if (rr < 6) begin
        if (m_typ == 0) begin typ = $urandom_range(1, 3); k = 1; end
        else if (m_pos == 3) begin typ = 0; k = 0; end
        else begin typ = m_typ; k = m_pos + 1; end
      end else if (rr < 8) begin
        typ = $urandom_range(0, 3); k = $urandom_range(1, 3);
      end else begin
        typ = -1; k = 0;
      end
      case (typ)
        0:       begin l = 3'b000;   r = 3'b000;   end
        1:       begin l = pat_of(k); r = 3'b000;  end
        2:       begin l = 3'b000;   r = pat_of(k); end
        3:       begin l = pat_of(k); r = pat_of(k); end
        default: begin l = 3'($urandom); r = 3'($urandom); end
      endcase
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else cyc($urandom_range(0, 4) != 0, l, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tail_light_decoder.md
Name: tail_light_decoder

Overview:
Receive-side checker for the tail-light pattern stream that the turn-signal controller drives onto L[2:0] and R[2:0].
- On each sample strobe, it classifies the pattern and tracks the expected left, right or hazard sequence.
- It reports completed sequences and protocol errors, with a status counter.
- It sits on the lamp-driver side, or in the bench, as the decoder for the controller's light outputs.

Parameters:
- CNT_W, 8, width of the completed-sequence counter and of the optional statistics counters.

Ports:
- Clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- sample_en  input  1  L/R hold a valid pattern this cycle; nothing changes when low.
- L  input  3  left lamp pattern.
- R  input  3  right lamp pattern.
- busy  output  1  high while inside a sequence (state not IDLE).
- left_done  output  1  one-cycle pulse: left sequence completed.
- right_done  output  1  one-cycle pulse: right sequence completed.
- hazard_done  output  1  one-cycle pulse: hazard sequence completed.
- err  output  1  one-cycle pulse: protocol violation.
- err_code  output  2  cause of the last error; held until the next error.
- seq_cnt  output  CNT_W  total completed sequences, wraps modulo 2^CNT_W.
- left_cnt, right_cnt, hazard_cnt, err_cnt  output  CNT_W each  statistics (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high, clock Clk): state IDLE. All outputs are 0, including busy, every pulse, err_code and all counters.
- Patterns: OFF=000, A=001, B=011, C=111.
- Pattern classes:
  - left step = (L in {A,B,C}, R=OFF)
  - right step = (R in {A,B,C}, L=OFF)
  - hazard step = (L=R in {A,B,C})
  - OFF = both 000
  - anything else is ILLEGAL
- States: IDLE, LA, LB, LC, RA, RB, RC, HA, HB, HC. They advance only in cycles where sample_en=1.
- IDLE transitions:
  - OFF: stay.
  - Left A -> LA; right A -> RA; hazard A -> HA.
  - Any B/C step: err, code 2'b10 (out-of-order), stay IDLE.
  - ILLEGAL: err, code 2'b01, stay IDLE.
- xA transitions (x = L, R or H, same type throughout): same-type B -> xB.
- xB transitions: same-type C -> xC.
- xC transitions: OFF -> IDLE, pulse matching *_done, seq_cnt+1.
- Mismatch handling in xA/xB/xC, in priority order:
  1. ILLEGAL: code 01, go IDLE.
  2. OFF before xC: code 11 (interrupted), go IDLE.
  3. Any other legal pattern: code 10.
     - If that pattern is an A step of any type, resync to its A state in the same cycle.
     - Otherwise go IDLE.
- Latency: pulses and err_code are registered. They appear in the cycle after the sampling edge, are high for exactly one cycle, and never overlap; at most one event per sample.
- A repeated pattern (no advance) while sample_en=1 is a mismatch; there is no hold tolerance.
- Reset asserted mid-sequence returns to IDLE immediately, with no done or err pulse.
- seq_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: TL_DEC_STATS_EN.
- When defined:
  - left_cnt, right_cnt and hazard_cnt increment with their done pulse.
  - err_cnt increments with err.
  - All four saturate at 2^CNT_W-1 and clear on reset.
- When undefined: the ports still exist and are tied to 0, and no counter flops are generated.
- seq_cnt is always present.

Decomposition:
- Package tl_pkg holds:
  - pattern constants PAT_OFF, PAT_A, PAT_B, PAT_C;
  - the state enum (10 states);
  - class enum {CL_OFF, CL_LEFT, CL_RIGHT, CL_HAZ, CL_ILLEGAL};
  - step enum {STEP_A, STEP_B, STEP_C};
  - error-code constants ERR_ILLEGAL=01, ERR_ORDER=10, ERR_INTR=11.
- One combinational sub-module, tl_pattern_classify: inputs L, R; outputs class and step. The FSM, pulse registers and counters stay in the top level.

Test Plan:
1. Left sequence: samples L=001,011,111,000 with R=000 -> busy high for 3 cycles; left_done pulse 1 cycle after the 000 sample; seq_cnt=1; err never asserted.
2. Hazard sequence: L=R=001,011,111 then 000 -> hazard_done single pulse; right_done and left_done stay 0; seq_cnt increments by 1.
3. Interrupt: R=001,011, then 000 -> err pulse with err_code=11; state IDLE; no right_done; seq_cnt unchanged.
4. Illegal and resync:
   - In IDLE, L=010 -> err_code=01.
   - Later, during LB, sample R=001 with L=000 -> err_code=10, and the next samples R=011,111,000 produce right_done.
5. sample_en gaps and reset:
   - Left sequence with sample_en low for 5 cycles between steps -> completes normally.
   - reset asserted during LC -> busy=0 asynchronously; no pulses; counters 0.
6. Counters with CNT_W=2: 5 left sequences -> seq_cnt=1 (wrapped). With TL_DEC_STATS_EN, left_cnt=3 (saturated); without it, left_cnt=0.
